// File: rtl/labcpu_port_bridge.sv
// labcpu_port_bridge: decodes a small register window into N registered output
// ports plus a buffered input FIFO with sticky overflow and a level interrupt.
module labcpu_port_bridge #(
  parameter int                         p_data_width    = 16,
  parameter int                         p_address_width = 10,
  parameter int                         p_port_width    = 8,
  parameter int                         p_num_ports     = 4,
  parameter int                         p_fifo_depth    = 8,
  parameter logic [p_address_width-1:0] p_base_address  = 10'h3F0
) (
  input  logic                                i_w_clk,
  input  logic                                i_w_reset,
  input  logic [p_address_width-1:0]          i_w_address,
  input  logic [p_data_width-1:0]             i_w_data_in,
  input  logic                                i_w_we,
  input  logic                                i_w_oe,
  output logic [p_data_width-1:0]             o_w_data_out,
  output logic                                o_w_hit,
  output logic [p_num_ports*p_port_width-1:0] o_w_out_ports,
  input  logic [p_port_width-1:0]             i_w_in_port,
  input  logic                                i_w_in_valid,
  output logic                                o_w_in_ready,
  output logic                                o_w_irq
);

  localparam int c_ptr_w = $clog2(p_fifo_depth);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [p_address_width-1:0] c_off_fifo   = p_address_width'(p_num_ports);
  localparam logic [p_address_width-1:0] c_off_status = p_address_width'(p_num_ports + 1);
  localparam logic [p_address_width-1:0] c_off_ctrl   = p_address_width'(p_num_ports + 2);
  localparam logic [p_address_width-1:0] c_off_limit  = p_address_width'(p_num_ports + 3);
  localparam logic [c_cnt_w-1:0]         c_cnt_full   = c_cnt_w'(p_fifo_depth);

  logic [p_address_width-1:0] offset_s;
  logic                       hit_s;
  logic                       wr_s;
  logic                       rd_s;
  logic                       full_s;
  logic                       empty_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       ovf_set_s;
  logic                       ovf_clr_s;
  logic [p_num_ports-1:0]     port_sel_s;
  logic [p_port_width-1:0]    port_rd_s;
  logic [p_data_width-1:0]    rd_data_s;
  logic                       unused_s;

  logic [p_port_width-1:0]    port_r [p_num_ports];
  logic [p_port_width-1:0]    mem_r  [p_fifo_depth];
  logic [c_ptr_w-1:0]         rd_ptr_r;
  logic [c_ptr_w-1:0]         wr_ptr_r;
  logic [c_cnt_w-1:0]         count_r;
  logic                       overflow_r;
  logic                       irq_en_r;
  logic                       irq_r;
  logic [p_data_width-1:0]    data_out_r;

  function automatic logic [p_data_width-1:0] status_word(
    input logic               empty,
    input logic               full,
    input logic               ovf,
    input logic [c_cnt_w-1:0] cnt
  );
    logic [p_data_width-1:0] w;
    w             = {p_data_width{1'b0}};
    w[0]          = empty;
    w[1]          = full;
    w[2]          = ovf;
    w[3 +: c_cnt_w] = cnt;
    return w;
  endfunction

  // Addresses below the base wrap to large offsets and so fall outside the window.
  assign offset_s  = i_w_address - p_base_address;
  assign hit_s     = (offset_s < c_off_limit);
  assign wr_s      = i_w_we & hit_s;
  assign rd_s      = i_w_oe & ~i_w_we & hit_s;
  assign full_s    = (count_r == c_cnt_full);
  assign empty_s   = (count_r == {c_cnt_w{1'b0}});
  assign push_s    = i_w_in_valid & ~full_s;
  assign pop_s     = rd_s & (offset_s == c_off_fifo) & ~empty_s;
  assign ovf_set_s = i_w_in_valid & full_s;
  assign ovf_clr_s = wr_s & (offset_s == c_off_status);
  assign unused_s  = ^i_w_data_in;

  assign o_w_hit      = hit_s;
  assign o_w_in_ready = ~full_s;
  assign o_w_data_out = data_out_r;
  assign o_w_irq      = irq_r;

  for (genvar k = 0; k < p_num_ports; k++) begin : g_port
    assign port_sel_s[k] = (offset_s == p_address_width'(k));
    assign o_w_out_ports[k*p_port_width +: p_port_width] = port_r[k];
  end

  // Select the addressed output port for readback (one-hot AND-OR mux).
  always_comb begin
    port_rd_s = {p_port_width{1'b0}};
    for (int k = 0; k < p_num_ports; k++) begin
      port_rd_s = port_rd_s | (port_r[k] & {p_port_width{port_sel_s[k]}});
    end
  end

  // Read data for the current offset, built from registered state only.
  always_comb begin
    rd_data_s = {p_data_width{1'b0}};
    if (offset_s < c_off_fifo) begin
      rd_data_s = p_data_width'(port_rd_s);
    end else if (offset_s == c_off_fifo) begin
      if (empty_s) begin
        rd_data_s = {p_data_width{1'b0}};
      end else begin
        rd_data_s = p_data_width'(mem_r[rd_ptr_r]);
      end
    end else if (offset_s == c_off_status) begin
      rd_data_s = status_word(empty_s, full_s, overflow_r, count_r);
    end else if (offset_s == c_off_ctrl) begin
      rd_data_s = p_data_width'(irq_en_r);
    end else begin
      rd_data_s = {p_data_width{1'b0}};
    end
  end

  // Output port registers.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      for (int k = 0; k < p_num_ports; k++) begin
        port_r[k] <= {p_port_width{1'b0}};
      end
    end else if (wr_s) begin
      for (int k = 0; k < p_num_ports; k++) begin
        if (port_sel_s[k]) begin
          port_r[k] <= i_w_data_in[p_port_width-1:0];
        end
      end
    end
  end

  // Input FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      for (int k = 0; k < p_fifo_depth; k++) begin
        mem_r[k] <= {p_port_width{1'b0}};
      end
      rd_ptr_r   <= {c_ptr_w{1'b0}};
      wr_ptr_r   <= {c_ptr_w{1'b0}};
      count_r    <= {c_cnt_w{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= i_w_in_port;
        wr_ptr_r        <= wr_ptr_r + c_ptr_w'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + c_ptr_w'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + c_cnt_w'(1);
        2'b01:   count_r <= count_r - c_cnt_w'(1);
        default: count_r <= count_r;
      endcase
      overflow_r <= ovf_set_s | (overflow_r & ~ovf_clr_s);
    end
  end

  // Read data register, interrupt enable and registered interrupt request.
  always_ff @(posedge i_w_clk or negedge i_w_reset) begin
    if (!i_w_reset) begin
      data_out_r <= {p_data_width{1'b0}};
      irq_en_r   <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      if (rd_s) begin
        data_out_r <= rd_data_s;
      end
      if (wr_s && (offset_s == c_off_ctrl)) begin
        irq_en_r <= i_w_data_in[0];
      end
      irq_r <= irq_en_r & (~empty_s | overflow_r);
    end
  end

endmodule

// File: tb/tb_labcpu_port_bridge.sv
// Self-checking bench for labcpu_port_bridge: directed scenarios plus random
// traffic, compared every cycle against a queue-based behavioural model.
module tb_labcpu_port_bridge;

  localparam int          N    = 4;
  localparam int          D    = 8;
  localparam logic [9:0]  BASE = 10'h3F0;

  logic        i_w_clk;
  logic        i_w_reset;
  logic [9:0]  i_w_address;
  logic [15:0] i_w_data_in;
  logic        i_w_we;
  logic        i_w_oe;
  logic [15:0] o_w_data_out;
  logic        o_w_hit;
  logic [31:0] o_w_out_ports;
  logic [7:0]  i_w_in_port;
  logic        i_w_in_valid;
  logic        o_w_in_ready;
  logic        o_w_irq;

  labcpu_port_bridge dut (
    .i_w_clk       (i_w_clk),
    .i_w_reset     (i_w_reset),
    .i_w_address   (i_w_address),
    .i_w_data_in   (i_w_data_in),
    .i_w_we        (i_w_we),
    .i_w_oe        (i_w_oe),
    .o_w_data_out  (o_w_data_out),
    .o_w_hit       (o_w_hit),
    .o_w_out_ports (o_w_out_ports),
    .i_w_in_port   (i_w_in_port),
    .i_w_in_valid  (i_w_in_valid),
    .o_w_in_ready  (o_w_in_ready),
    .o_w_irq       (o_w_irq)
  );

  initial i_w_clk = 1'b0;
  always #5 i_w_clk = ~i_w_clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state
  logic [7:0]  m_port [N];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  bit          m_irq_en;
  bit          m_irq;
  logic [15:0] m_dout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_port[k] = 8'h00;
    m_q.delete();
    m_ovf    = 1'b0;
    m_irq_en = 1'b0;
    m_irq    = 1'b0;
    m_dout   = 16'h0000;
  endtask

  task automatic compare_all();
    logic [31:0] ep;
    for (int k = 0; k < N; k++) ep[k*8 +: 8] = m_port[k];
    chk("data_out", o_w_data_out, m_dout);
    chk("out_ports", o_w_out_ports, ep);
    chk("in_ready", o_w_in_ready, (m_q.size() != D));
    chk("irq", o_w_irq, m_irq);
  endtask

  // One bus cycle: drive at the falling edge, update model, compare after the next rising edge.
  task automatic cycle(input logic [9:0] a, input logic [15:0] d, input bit we,
                       input bit oe, input bit v, input logic [7:0] pin);
    logic [9:0]  off10;
    int          off;
    bit          hit, full, empty, wr, rd, nirq;
    logic [15:0] rv;
    i_w_address  = a;
    i_w_data_in  = d;
    i_w_we       = we;
    i_w_oe       = oe;
    i_w_in_valid = v;
    i_w_in_port  = pin;
    off10 = a - BASE;
    off   = int'(off10);
    hit   = (off < N + 3);
    #1;
    chk("hit", o_w_hit, hit);
    full  = (m_q.size() == D);
    empty = (m_q.size() == 0);
    wr    = we && hit;
    rd    = oe && !we && hit;
    nirq  = m_irq_en && (!empty || m_ovf);
    rv    = 16'h0000;
    if (off < N)          rv = {8'h00, m_port[off]};
    else if (off == N)    rv = empty ? 16'h0000 : {8'h00, m_q[0]};
    else if (off == N + 1) rv = {9'h000, 4'(m_q.size()), m_ovf, full, empty};
    else if (off == N + 2) rv = {15'h0000, m_irq_en};
    if (rd) m_dout = rv;
    if (rd && off == N && !empty) void'(m_q.pop_front());
    if (v && !full) m_q.push_back(pin);
    m_ovf = (v && full) || (m_ovf && !(wr && off == N + 1));
    if (wr && off < N) m_port[off] = d[7:0];
    if (wr && off == N + 2) m_irq_en = d[0];
    m_irq = nirq;
    @(posedge i_w_clk);
    @(negedge i_w_clk);
    compare_all();
  endtask

  task automatic idle();
    cycle(10'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [9:0] ra;
    model_reset();
    i_w_reset = 1'b0; i_w_address = 10'h000; i_w_data_in = 16'h0000;
    i_w_we = 1'b0; i_w_oe = 1'b0; i_w_in_valid = 1'b0; i_w_in_port = 8'h00;
    @(negedge i_w_clk); @(negedge i_w_clk);
    chk("rst_dout", o_w_data_out, 16'h0000);
    chk("rst_ports", o_w_out_ports, 32'h0000_0000);
    chk("rst_ready", o_w_in_ready, 1'b1);
    chk("rst_irq", o_w_irq, 1'b0);
    i_w_reset = 1'b1;

    // Port writes and readback
    cycle(BASE + 10'd0, 16'h00A5, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("lit_port0", o_w_out_ports[7:0], 8'hA5);
    cycle(BASE + 10'd3, 16'h1234, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("lit_port3", o_w_out_ports[31:24], 8'h34);
    cycle(BASE + 10'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_rd_port0", o_w_data_out, 16'h00A5);
    cycle(BASE + 10'd3, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_rd_port3", o_w_data_out, 16'h0034);
    // Write and read together: write wins, read data holds
    cycle(BASE + 10'd1, 16'h0077, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("lit_we_oe_hold", o_w_data_out, 16'h0034);
    chk("lit_we_oe_port1", o_w_out_ports[15:8], 8'h77);
    // Outside the window: no effect
    cycle(BASE - 10'd1, 16'h00EE, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(BASE + 10'd7, 16'h00EE, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("lit_outside_port0", o_w_out_ports[7:0], 8'hA5);

    // FIFO fill, overflow, clear, drain
    for (int i = 1; i <= 8; i++) cycle(10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'(i));
    chk("lit_ready_full", o_w_in_ready, 1'b0);
    cycle(BASE + 10'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_status_full", o_w_data_out, 16'h0042);
    cycle(10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h99);
    cycle(BASE + 10'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_status_ovf", o_w_data_out, 16'h0046);
    cycle(BASE + 10'd5, 16'hFFFF, 1'b1, 1'b0, 1'b0, 8'h00);
    cycle(BASE + 10'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_status_clr", o_w_data_out, 16'h0042);
    for (int i = 1; i <= 8; i++) begin
      cycle(BASE + 10'd4, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("lit_drain", o_w_data_out, 64'(i));
    end
    cycle(BASE + 10'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_status_empty", o_w_data_out, 16'h0001);
    cycle(BASE + 10'd4, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_pop_empty", o_w_data_out, 16'h0000);

    // Interrupt
    cycle(BASE + 10'd6, 16'h0001, 1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    chk("lit_irq_empty", o_w_irq, 1'b0);
    cycle(10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h5A);
    chk("lit_irq_lag", o_w_irq, 1'b0);
    idle();
    chk("lit_irq_set", o_w_irq, 1'b1);
    cycle(BASE + 10'd4, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_irq_pop", o_w_data_out, 16'h005A);
    idle();
    chk("lit_irq_clr", o_w_irq, 1'b0);

    // Streaming push+pop at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) cycle(10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'(8'h30 + i));
    for (int i = 0; i < 24; i++) cycle(BASE + 10'd4, 16'h0000, 1'b0, 1'b1, 1'b1, 8'(8'h40 + i));
    cycle(BASE + 10'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_stream_count", o_w_data_out, 16'h0018);

    // Asynchronous reset between edges during a burst
    for (int i = 0; i < 3; i++) cycle(10'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 8'(8'h70 + i));
    i_w_in_valid = 1'b1;
    #2;
    i_w_reset = 1'b0;
    #1;
    chk("lit_arst_ports", o_w_out_ports, 32'h0000_0000);
    chk("lit_arst_dout", o_w_data_out, 16'h0000);
    chk("lit_arst_ready", o_w_in_ready, 1'b1);
    chk("lit_arst_irq", o_w_irq, 1'b0);
    model_reset();
    @(negedge i_w_clk);
    i_w_reset    = 1'b1;
    i_w_in_valid = 1'b0;
    cycle(BASE + 10'd5, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("lit_arst_status", o_w_data_out, 16'h0001);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      ra = BASE - 10'd2 + 10'($urandom_range(0, 10));
      cycle(ra, 16'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
